// File: rtl/capture_sequencer.sv
// Capture sequencer: decimated circular-buffer capture with pre-trigger fill, post-trigger
// count and oldest-first dump. Optional auto re-arm after a dump: CAPTURE_AUTO_REARM_EN.
module capture_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              smpl_en,
  input  logic              triggered,
  input  logic              dump_req,
  input  logic              byte_taken,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  output logic              rdata_vld,
  output logic              armed,
  output logic              capture_done,
  output logic              dump_busy
);

  localparam int DEC_CNT_W = (1 << DEC_W) - 1;
  localparam logic [ADDR_W:0]      DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]      FILL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [DEC_CNT_W-1:0] DEC_ONE  = {{(DEC_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DUMP  = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [DEC_CNT_W-1:0] dec_cnt_r, dec_limit_s;
  logic [DEC_W-1:0]     dec_lat_r;
  logic [ADDR_W-1:0]    trig_lat_r;
  logic [ADDR_W:0]      fill_r;
  logic [ADDR_W-1:0]    post_r, post_inc_s;
  logic [ADDR_W-1:0]    dump_cnt_r;
  logic [ADDR_W-1:0]    waddr_r, raddr_r;
  logic                 re_r, rdata_vld_r;
  logic                 armed_r, done_r, busy_r;
  logic                 keep_s, capturing_s, arm_go_s, we_s, trig_ok_s;
  logic                 take_s, last_byte_s, rearm_s, dump_start_s;

  // Keep detection, write qualification and dump handshake decode.
  always_comb begin
    dec_limit_s  = ~({DEC_CNT_W{1'b1}} << dec_lat_r);
    keep_s       = smpl_en & (dec_cnt_r == dec_limit_s);
    capturing_s  = (state_r == ST_ARMED) || (state_r == ST_RUN);
    arm_go_s     = arm & (state_r != ST_DUMP);
    we_s         = keep_s & capturing_s & ~arm_go_s;
    trig_ok_s    = (fill_r >= (DEPTH_C - {1'b0, trig_lat_r}));
    post_inc_s   = post_r + ADDR_ONE;
    take_s       = (state_r == ST_DUMP) & rdata_vld_r & byte_taken;
    last_byte_s  = take_s & (dump_cnt_r == ADDR_MAX);
  end

  // Next-state logic; arm outranks every other request except while dumping.
  always_comb begin
    state_nxt_s  = state_r;
    rearm_s      = 1'b0;
    dump_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm_go_s) state_nxt_s = ST_ARMED;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (arm_go_s)                   state_nxt_s = ST_ARMED;
        else if (triggered & trig_ok_s) state_nxt_s = (trig_lat_r == {ADDR_W{1'b0}}) ? ST_DONE : ST_RUN;
        else                            state_nxt_s = ST_ARMED;
      end
      ST_RUN: begin
        if (arm_go_s)                           state_nxt_s = ST_ARMED;
        else if (we_s && post_inc_s == trig_lat_r) state_nxt_s = ST_DONE;
        else                                    state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (arm_go_s) begin
          state_nxt_s = ST_ARMED;
        end else if (dump_req) begin
          state_nxt_s  = ST_DUMP;
          dump_start_s = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DUMP: begin
        if (last_byte_s) begin
`ifdef CAPTURE_AUTO_REARM_EN
          state_nxt_s = ST_ARMED;
          rearm_s     = 1'b1;
`else
          state_nxt_s = ST_IDLE;
`endif
        end else begin
          state_nxt_s = ST_DUMP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      armed_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      armed_r <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s == ST_DUMP);
    end
  end

  // Capture datapath: decimation, write pointer, fill and post-trigger counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_r  <= {DEC_CNT_W{1'b0}};
      dec_lat_r  <= {DEC_W{1'b0}};
      trig_lat_r <= {ADDR_W{1'b0}};
      waddr_r    <= {ADDR_W{1'b0}};
      fill_r     <= {(ADDR_W+1){1'b0}};
      post_r     <= {ADDR_W{1'b0}};
    end else begin
      if (arm_go_s) begin
        trig_lat_r <= trig_pos;
        dec_lat_r  <= decimator;
      end
      if (arm_go_s || rearm_s)  dec_cnt_r <= {DEC_CNT_W{1'b0}};
      else if (keep_s)          dec_cnt_r <= {DEC_CNT_W{1'b0}};
      else if (smpl_en)         dec_cnt_r <= dec_cnt_r + DEC_ONE;
      if (arm_go_s || rearm_s)  waddr_r <= {ADDR_W{1'b0}};
      else if (we_s)            waddr_r <= waddr_r + ADDR_ONE;
      if (arm_go_s || rearm_s)  fill_r <= {(ADDR_W+1){1'b0}};
      else if (we_s && state_r == ST_ARMED && fill_r != DEPTH_C) fill_r <= fill_r + FILL_ONE;
      // Post count only lives inside RUN, so it is zero on every entry.
      if (state_r != ST_RUN)    post_r <= {ADDR_W{1'b0}};
      else if (we_s)            post_r <= post_inc_s;
    end
  end

  // Dump datapath: one read per byte, data valid held until the host takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_r     <= {ADDR_W{1'b0}};
      dump_cnt_r  <= {ADDR_W{1'b0}};
      re_r        <= 1'b0;
      rdata_vld_r <= 1'b0;
    end else if (dump_start_s) begin
      raddr_r     <= waddr_r;
      dump_cnt_r  <= {ADDR_W{1'b0}};
      re_r        <= 1'b1;
      rdata_vld_r <= 1'b0;
    end else if (state_r == ST_DUMP) begin
      if (re_r) begin
        re_r        <= 1'b0;
        rdata_vld_r <= 1'b1;
      end else if (take_s) begin
        rdata_vld_r <= 1'b0;
        raddr_r     <= raddr_r + ADDR_ONE;
        dump_cnt_r  <= dump_cnt_r + ADDR_ONE;
        re_r        <= ~last_byte_s;
      end
    end else begin
      re_r        <= 1'b0;
      rdata_vld_r <= 1'b0;
    end
  end

  assign we           = we_s;
  assign waddr        = waddr_r;
  assign re           = re_r;
  assign raddr        = raddr_r;
  assign rdata_vld    = rdata_vld_r;
  assign armed        = armed_r;
  assign capture_done = done_r;
  assign dump_busy    = busy_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: randomized stimulus against a count-based
// behavioural model of capture, trigger window and dump (honours CAPTURE_AUTO_REARM_EN).
module tb_capture_sequencer;
  localparam int ADDR_W = 9;
  localparam int DEC_W  = 4;
  localparam int D      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, smpl_en = 1'b0, triggered = 1'b0, dump_req = 1'b0, byte_taken = 1'b0;
  logic [ADDR_W-1:0] trig_pos = '0;
  logic [DEC_W-1:0]  decimator = '0;
  logic we, re, rdata_vld, armed, capture_done, dump_busy;
  logic [ADDR_W-1:0] waddr, raddr;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts since arm, not RTL registers.
  int   m_phase;    // 0 idle, 1 armed, 2 run, 3 done, 4 dump
  int   m_strobes, m_written, m_fill, m_post, m_tp, m_dec, m_base, m_reads;
  logic m_re, m_vld;

  always #5 clk = ~clk;

  capture_sequencer #(.ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_pos(trig_pos), .decimator(decimator),
    .smpl_en(smpl_en), .triggered(triggered), .dump_req(dump_req), .byte_taken(byte_taken),
    .we(we), .waddr(waddr), .re(re), .raddr(raddr), .rdata_vld(rdata_vld),
    .armed(armed), .capture_done(capture_done), .dump_busy(dump_busy)
  );

  function automatic void model_reset();
    m_phase = 0; m_strobes = 0; m_written = 0; m_fill = 0; m_post = 0;
    m_tp = 0; m_dec = 0; m_base = 0; m_reads = 0; m_re = 1'b0; m_vld = 1'b0;
  endfunction

  function automatic logic model_we();
    int period;
    period = 1 << m_dec;
    return smpl_en && ((m_strobes % period) == period - 1) &&
           (m_phase == 1 || m_phase == 2) && !(arm && m_phase != 4);
  endfunction

  function automatic logic [23:0] model_vec();
    logic [ADDR_W-1:0] wa, ra;
    wa = ADDR_W'(m_written % D);
    ra = ADDR_W'((m_base + m_reads) % D);
    return {model_we(), wa, m_re, ra, m_vld, (m_phase == 1 || m_phase == 2), (m_phase == 3), (m_phase == 4)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {we, waddr, re, raddr, rdata_vld, armed, capture_done, dump_busy};
  endfunction

  function automatic void model_update();
    logic w;
    int   fill_old;
    w = model_we();
    if (arm && m_phase != 4) begin
      m_phase = 1; m_written = 0; m_fill = 0; m_strobes = 0; m_post = 0;
      m_tp = int'(trig_pos); m_dec = int'(decimator);
    end else begin
      if (smpl_en) m_strobes++;
      case (m_phase)
        1: begin
          fill_old = m_fill;
          if (w) begin
            m_written++;
            if (m_fill < D) m_fill++;
          end
          if (triggered && fill_old >= D - m_tp) begin
            if (m_tp == 0) m_phase = 3;
            else begin m_phase = 2; m_post = 0; end
          end
        end
        2: if (w) begin
          m_written++; m_post++;
          if (m_post == m_tp) m_phase = 3;
        end
        3: if (dump_req) begin
          m_phase = 4; m_base = m_written % D; m_reads = 0; m_re = 1'b1; m_vld = 1'b0;
        end
        4: begin
          if (m_re) begin
            m_re = 1'b0; m_vld = 1'b1;
          end else if (m_vld && byte_taken) begin
            m_vld = 1'b0; m_reads++;
            if (m_reads == D) begin
`ifdef CAPTURE_AUTO_REARM_EN
              m_phase = 1; m_written = 0; m_fill = 0; m_strobes = 0;
`else
              m_phase = 0;
`endif
            end else begin
              m_re = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic drive(input logic a, input logic t, input logic s, input logic d, input logic b);
    @(negedge clk);
    arm = a; triggered = t; smpl_en = s; dump_req = d; byte_taken = b;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), 24'h0);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_trigger_window();
    int post_writes;
    post_writes = 0;
    trig_pos = ADDR_W'(100); decimator = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int k = 1; k <= 530; k++) begin
      drive(1'b0, (k == 300) || (k == 420), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL window k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      if (k == 301) begin
        checks++;
        if (capture_done !== 1'b0 || armed !== 1'b1) begin
          errors++; $display("FAIL early_trigger done=%b armed=%b exp 0/1", capture_done, armed);
        end
      end
      if (k > 420 && we === 1'b1) post_writes++;
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (post_writes != 100 || capture_done !== 1'b1 || waddr !== ADDR_W'(8)) begin
      errors++;
      $display("FAIL window_end writes=%0d done=%b waddr=%0d exp 100/1/8", post_writes, capture_done, waddr);
    end
    advance();
  endtask

  task automatic test_dump();
    int   nreads, age, cyc;
    logic bt, fin;
    logic [ADDR_W-1:0] exp_ra;
    nreads = 0; age = 0; fin = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); advance();
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      bt = (age == 3);
      drive(1'b0, 1'b0, 1'b0, 1'b0, bt);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL dump cyc=%0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
      if (re === 1'b1) begin
        exp_ra = ADDR_W'((8 + nreads) % D);
        checks++;
        if (raddr !== exp_ra) begin
          errors++; $display("FAIL dump_raddr n=%0d got %0d exp %0d", nreads, raddr, exp_ra);
        end
        nreads++;
      end
      if (rdata_vld === 1'b1) age++;
      else age = 0;
      if (nreads == D && dump_busy === 1'b0) fin = 1'b1;
      advance();
    end
    checks++;
`ifdef CAPTURE_AUTO_REARM_EN
    if (!fin || nreads != D || armed !== 1'b1) begin
`else
    if (!fin || nreads != D || armed !== 1'b0) begin
`endif
      errors++; $display("FAIL dump_end fin=%b reads=%0d armed=%b", fin, nreads, armed);
    end
  endtask

  task automatic test_decimation();
    int wcount;
    wcount = 0;
    trig_pos = '0; decimator = DEC_W'(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int k = 0; k < 64; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL decim k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      if (we === 1'b1) wcount++;
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wcount != 16 || waddr !== ADDR_W'(16)) begin
      errors++; $display("FAIL decim_rate writes=%0d waddr=%0d exp 16/16", wcount, waddr);
    end
    advance();
    for (int k = 0; k < 200; k++) begin
      decimator = DEC_W'($urandom_range(0, 15));
      drive(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL decim_rand k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      advance();
    end
  endtask

  task automatic test_trig_pos_zero();
    trig_pos = '0; decimator = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int k = 1; k <= 600; k++) begin
      drive(1'b0, (k == 512) || (k == 600), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL tp0 k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      if (k == 513 || k == 600) begin
        checks++;
        if (capture_done !== 1'b0 || we !== 1'b1) begin
          errors++; $display("FAIL tp0_window k=%0d done=%b we=%b exp 0/1", k, capture_done, we);
        end
      end
      advance();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (we !== 1'b0 || capture_done !== 1'b1 || waddr !== ADDR_W'(88)) begin
        errors++; $display("FAIL tp0_done we=%b done=%b waddr=%0d exp 0/1/88", we, capture_done, waddr);
      end
      advance();
    end
  endtask

  task automatic test_arm_trig_same_cycle();
    trig_pos = ADDR_W'(5); decimator = '0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (armed !== 1'b1 || capture_done !== 1'b0 || waddr !== '0) begin
      errors++; $display("FAIL arm_trig armed=%b done=%b waddr=%0d exp 1/0/0", armed, capture_done, waddr);
    end
    advance();
    // Fill restarted at 0: trigger at fill 506 must be ignored, at fill 507 accepted.
    for (int k = 1; k <= 520; k++) begin
      drive(1'b0, (k == 507) || (k == 508), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL arm_trig k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (capture_done !== 1'b1 || waddr !== ADDR_W'(513 % D)) begin
      errors++; $display("FAIL arm_trig_end done=%b waddr=%0d exp 1/1", capture_done, waddr);
    end
    advance();
  endtask

  task automatic test_random();
    int   cyc, age, lim;
    logic fin;
    for (int it = 0; it < 2; it++) begin
      trig_pos  = ADDR_W'($urandom_range(0, 300));
      decimator = DEC_W'($urandom_range(0, 1));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
      fin = 1'b0;
      for (cyc = 0; cyc < 6000 && !fin; cyc++) begin
        drive(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 31) == 0), 1'b0);
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL rand_cap it=%0d cyc=%0d got %h exp %h", it, cyc, dut_vec(), model_vec());
        end
        if (capture_done === 1'b1) fin = 1'b1;
        advance();
      end
      if (!fin) begin
        errors++; $display("FAIL rand_cap_timeout it=%0d done=%b exp 1", it, capture_done);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); advance();
      fin = 1'b0; age = 0; lim = $urandom_range(0, 2);
      for (cyc = 0; cyc < 5000 && !fin; cyc++) begin
        drive((dump_busy === 1'b1) && ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              1'b0, ($urandom_range(0, 7) == 0), (age > lim));
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL rand_dump it=%0d cyc=%0d got %h exp %h", it, cyc, dut_vec(), model_vec());
        end
        if (rdata_vld === 1'b1) age++;
        else begin age = 0; lim = $urandom_range(0, 2); end
        if (dump_busy === 1'b0 && m_phase != 4) fin = 1'b1;
        advance();
      end
      if (!fin) begin
        errors++; $display("FAIL rand_dump_timeout it=%0d busy=%b exp 0", it, dump_busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    trig_pos = ADDR_W'(50); decimator = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); advance();
    for (int k = 1; k <= 475; k++) begin
      drive(1'b0, (k == 470), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL pre_reset k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_phase != 2 || m_post != 5 || we !== 1'b1) begin
      errors++; $display("FAIL run_post5 post=%0d we=%b exp 5/1", m_post, we);
    end
    rst = 1'b1;
    arm = 1'b0; triggered = 1'b0; smpl_en = 1'b0; dump_req = 1'b0; byte_taken = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 24'h0) begin
      errors++; $display("FAIL async_reset got %h exp %h", dut_vec(), 24'h0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, k[0], 1'b1, 1'b0, 1'b0);
      checks++;
      if (we !== 1'b0 || dut_vec() !== model_vec()) begin
        errors++; $display("FAIL post_reset k=%0d got %h exp %h", k, dut_vec(), model_vec());
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_trigger_window();
    test_dump();
    test_decimation();
    test_trig_pos_zero();
    test_arm_trig_same_cycle();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences sample-RAM capture and dump for the logic-analyzer digital core.
- Sits between the channel sampling/trigger logic and the UART command/response path.
- Arms a circular-buffer capture and honours decimation.
- Enforces the pre-trigger fill, counts post-trigger samples, then streams the buffer oldest-first to the host under a byte handshake.

Parameters:
- ADDR_W, 9, sample-RAM address width; depth D = 2^ADDR_W.
- DEC_W, 4, width of the decimation exponent.

Ports:
- clk  in  1  system clock (100MHz domain).
- rst  in  1  asynchronous active-high reset.
- arm  in  1  one-cycle pulse from the command decoder; starts a capture.
- trig_pos  in  ADDR_W  number of post-trigger samples to store.
- decimator  in  DEC_W  store one sample per 2^decimator smpl_en pulses.
- smpl_en  in  1  sample strobe from the channel sampler.
- triggered  in  1  trigger-logic pulse (level or protocol trigger).
- dump_req  in  1  one-cycle pulse; start dump (honoured only in DONE).
- byte_taken  in  1  pulse from the UART transmitter; current sample consumed.
- we  out  1  RAM write enable.
- waddr  out  ADDR_W  RAM write address.
- re  out  1  RAM read enable.
- raddr  out  ADDR_W  RAM read address.
- rdata_vld  out  1  RAM read data valid; RAM read latency is 1 cycle.
- armed  out  1  status: in ARMED or RUN.
- capture_done  out  1  status: in DONE.
- dump_busy  out  1  status: in DUMP.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; waddr=0, raddr=0; decimation counter, fill counter and post counter cleared.
- Decimation:
  - Counter increments on smpl_en.
  - A "keep" event occurs on smpl_en when the counter equals 2^decimator-1; the counter then wraps to 0.
  - decimator=0 makes every smpl_en a keep.
  - Counter is cleared on arm.
- On every keep in ARMED or RUN: we=1 for that cycle, write at waddr; waddr increments next cycle and wraps D-1 to 0.
- The fill counter (ADDR_W+1 bits) counts keeps in ARMED and saturates at D.
- State machine:
  - IDLE: arm -> ARMED. This also clears waddr, the fill counter and the decimation counter, and latches trig_pos and decimator.
  - ARMED: triggered is accepted only when fill >= D - trig_pos_latched; otherwise it is ignored.
    - Accepted with trig_pos=0 -> DONE. No further writes; a keep in the same cycle as acceptance is still written.
    - Accepted otherwise -> RUN with the post counter set to 0.
  - RUN: each keep increments the post counter; the keep that makes it equal trig_pos_latched -> DONE. That final sample is written.
  - DONE: waddr is frozen and points at the oldest sample. dump_req -> DUMP with raddr=waddr and the dump counter=0. arm -> ARMED (fresh capture, old data discarded).
  - DUMP:
    - re=1 for one cycle at raddr; rdata_vld=1 on the following cycle and held until byte_taken.
    - On byte_taken: raddr+1 (wraps), dump counter+1, and the next re is issued the following cycle.
    - After the D-th byte_taken -> IDLE (see optional feature).
- Priority: arm outranks triggered and dump_req in the same cycle; arm is ignored in DUMP.
- triggered and dump_req outside their valid states: ignored, no side effects.
- byte_taken while rdata_vld=0: ignored.
- Reset mid-capture or mid-dump: immediate return to IDLE, outputs 0; a pending rdata_vld is dropped.
- Parameters are latched at arm; changes during a capture take effect on the next arm.

Optional Feature:
- Macro: CAPTURE_AUTO_REARM_EN.
- Defined: after the D-th byte_taken, DUMP -> ARMED, with the fill counter, waddr and decimation counter cleared and the previous trig_pos/decimator reused. armed rises the cycle after the last byte_taken.
- Not defined: DUMP -> IDLE; the host must issue arm again.

Test Plan:
- Reset mid-RUN (rst pulsed at post count 5) -> we/re/status all 0 asynchronously, state IDLE; a subsequent triggered pulse produces no writes.
- ADDR_W=9, decimator=0, trig_pos=100, smpl_en every cycle, triggered at keep 300 -> trigger ignored (fill<412); triggered again at keep 420 -> exactly 100 further writes, capture_done=1, waddr frozen at (420+100) mod 512=8.
- decimator=2, smpl_en continuous -> we pulses on every 4th smpl_en; waddr advances 1 per 4 strobes.
- trig_pos=0, fill=512, triggered -> DONE the next cycle; the keep coinciding with the trigger is written, no further we.
- Dump after the test-2 capture: dump_req, byte_taken 3 cycles after each rdata_vld -> raddr sequence 8,9,...,511,0,...,7 (512 reads), then dump_busy=0, IDLE; with CAPTURE_AUTO_REARM_EN defined, armed=1 instead.
- arm and triggered in the same cycle while in DONE -> enters ARMED with fill=0; the trigger is not accepted.
